// File: rtl/i2c_pkg.sv
// Shared I2C definitions: widths, ACK/NACK levels and the target FSM state encoding.
package i2c_pkg;
    localparam int   I2C_ADDR_W = 7;
    localparam int   I2C_DATA_W = 8;
    localparam logic I2C_ACK    = 1'b0;
    localparam logic I2C_NACK   = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ACK_ADDR,
        ST_RX_DATA,
        ST_ACK_DATA,
        ST_TX_DATA,
        ST_RX_ACK,
        ST_WAIT_STOP
    } i2c_state_e;
endpackage

// File: rtl/i2c_slave_if.sv
// Local-side byte interface of the I2C target: tx byte supply, rx byte delivery and status pulses.
interface i2c_slave_if;
    import i2c_pkg::*;

    logic [I2C_DATA_W-1:0] iw_tx_data;
    logic                  ow_tx_load;
    logic [I2C_DATA_W-1:0] ow_rx_data;
    logic                  ow_rx_valid;
    logic                  ow_stop;
    logic                  ow_busy;

    modport slave (
        input  iw_tx_data,
        output ow_tx_load, ow_rx_data, ow_rx_valid, ow_stop, ow_busy
    );

    modport master (
        output iw_tx_data,
        input  ow_tx_load, ow_rx_data, ow_rx_valid, ow_stop, ow_busy
    );
endinterface

// File: rtl/i2c_line_cond.sv
// Conditions one open-drain bus line: synchroniser, optional glitch filter
// (I2C_SLAVE_GLITCH_FILTER_EN) and rise/fall detection on the conditioned level.
module i2c_line_cond #(
    parameter int SYNC_STAGES = 2
`ifdef I2C_SLAVE_GLITCH_FILTER_EN
    , parameter int FILTER_LEN = 3
`endif
) (
    input  logic clk,
    input  logic rst_n,
    input  logic line_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   synced;
    logic                   level;
    logic                   prev_q;

    // Bus idles high, so every stage resets to 1 to avoid a phantom edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], line_i};
        end
    end

    assign synced = sync_q[SYNC_STAGES-1];

`ifdef I2C_SLAVE_GLITCH_FILTER_EN
    localparam int CNT_W = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

    logic [CNT_W-1:0] cnt_q;
    logic             filt_q;
    logic             settle;

    // The FILTER_LEN-th differing sample passes through combinationally,
    // which keeps the added latency at FILTER_LEN-1 cycles.
    assign settle = (synced != filt_q) && (cnt_q == CNT_W'(FILTER_LEN - 1));
    assign level  = settle ? synced : filt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            filt_q <= 1'b1;
        end else if ((synced == filt_q) || settle) begin
            cnt_q  <= '0;
            filt_q <= synced;
        end else begin
            cnt_q  <= cnt_q + 1'b1;
        end
    end
`else
    assign level = synced;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_q <= 1'b1;
        end else begin
            prev_q <= level;
        end
    end

    assign level_o = level;
    assign rise_o  = level & ~prev_q;
    assign fall_o  = ~level & prev_q;
endmodule

// File: rtl/i2c_slave.sv
// Single-address I2C target without clock stretching; SDA is open-drain (0 or Z).
// Build option I2C_SLAVE_GLITCH_FILTER_EN enables the per-line glitch filter.
module i2c_slave
    import i2c_pkg::*;
#(
    parameter logic [I2C_ADDR_W-1:0] SLAVE_ADDR  = 7'h42,
    parameter int                    SYNC_STAGES = 2,
    parameter int                    FILTER_LEN  = 3
) (
    input  logic        iw_clk,
    input  logic        iw_reset_n,
    input  logic        iw_i2c_scl,
    inout  wire         io_i2c_sda,
    i2c_slave_if.slave  local_if
);
    if (SYNC_STAGES < 2 || FILTER_LEN < 1) begin : g_param_check
        $error("i2c_slave: SYNC_STAGES must be >= 2 and FILTER_LEN >= 1");
    end

    logic scl_level, scl_rise, scl_fall;
    logic sda_level, sda_rise, sda_fall;

    i2c_line_cond #(
        .SYNC_STAGES(SYNC_STAGES)
`ifdef I2C_SLAVE_GLITCH_FILTER_EN
        , .FILTER_LEN(FILTER_LEN)
`endif
    ) u_scl_cond (
        .clk(iw_clk), .rst_n(iw_reset_n), .line_i(iw_i2c_scl),
        .level_o(scl_level), .rise_o(scl_rise), .fall_o(scl_fall)
    );

    i2c_line_cond #(
        .SYNC_STAGES(SYNC_STAGES)
`ifdef I2C_SLAVE_GLITCH_FILTER_EN
        , .FILTER_LEN(FILTER_LEN)
`endif
    ) u_sda_cond (
        .clk(iw_clk), .rst_n(iw_reset_n), .line_i(io_i2c_sda),
        .level_o(sda_level), .rise_o(sda_rise), .fall_o(sda_fall)
    );

    i2c_state_e            state_q;
    logic [2:0]            bit_cnt_q;
    logic [I2C_DATA_W-2:0] shift_q;
    logic [I2C_DATA_W-2:0] tx_q;
    logic                  rw_q;
    logic                  ack_seen_q;
    logic                  sda_low_q;
    logic [I2C_DATA_W-1:0] rx_data_q;
    logic                  rx_valid_q;
    logic                  stop_q;
    logic                  busy_q;

    logic                  start_det;
    logic                  stop_det;
    logic [I2C_DATA_W-1:0] byte_in;
    logic                  load_now;

    assign start_det = sda_fall & scl_level;
    assign stop_det  = sda_rise & scl_level;
    assign byte_in   = {shift_q, sda_level};

    // The tx byte is captured in the very cycle ow_tx_load is high, so the
    // strobe is decoded rather than registered.
    assign load_now = ~start_det & ~stop_det & scl_fall &
                      (((state_q == ST_ACK_ADDR) & sda_low_q & rw_q) |
                       ((state_q == ST_RX_ACK) & ack_seen_q));

    always_ff @(posedge iw_clk or negedge iw_reset_n) begin
        if (!iw_reset_n) begin
            state_q    <= ST_IDLE;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            tx_q       <= '0;
            rw_q       <= 1'b0;
            ack_seen_q <= 1'b0;
            sda_low_q  <= 1'b0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            stop_q     <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            rx_valid_q <= 1'b0;
            stop_q     <= 1'b0;
            if (start_det) begin
                state_q   <= ST_ADDR;
                bit_cnt_q <= 3'd7;
                sda_low_q <= 1'b0;
            end else if (stop_det) begin
                state_q   <= ST_IDLE;
                bit_cnt_q <= '0;
                sda_low_q <= 1'b0;
                busy_q    <= 1'b0;
                stop_q    <= busy_q;
            end else begin
                case (state_q)
                    ST_ADDR: if (scl_rise) begin
                        shift_q <= byte_in[I2C_DATA_W-2:0];
                        if (bit_cnt_q == 3'd0) begin
                            rw_q <= byte_in[0];
                            if (byte_in[I2C_DATA_W-1:1] == SLAVE_ADDR) begin
                                state_q <= ST_ACK_ADDR;
                                busy_q  <= 1'b1;
                            end else begin
                                state_q <= ST_WAIT_STOP;
                                busy_q  <= 1'b0;
                            end
                        end else begin
                            bit_cnt_q <= bit_cnt_q - 3'd1;
                        end
                    end
                    // First fall after bit 8 starts the ACK, the next one ends it.
                    ST_ACK_ADDR: if (scl_fall) begin
                        if (!sda_low_q) begin
                            sda_low_q <= 1'b1;
                        end else if (rw_q) begin
                            state_q   <= ST_TX_DATA;
                            tx_q      <= local_if.iw_tx_data[I2C_DATA_W-2:0];
                            sda_low_q <= ~local_if.iw_tx_data[I2C_DATA_W-1];
                            bit_cnt_q <= 3'd7;
                        end else begin
                            state_q   <= ST_RX_DATA;
                            sda_low_q <= 1'b0;
                            bit_cnt_q <= 3'd7;
                        end
                    end
                    ST_RX_DATA: if (scl_rise) begin
                        shift_q <= byte_in[I2C_DATA_W-2:0];
                        if (bit_cnt_q == 3'd0) begin
                            rx_data_q  <= byte_in;
                            rx_valid_q <= 1'b1;
                            state_q    <= ST_ACK_DATA;
                        end else begin
                            bit_cnt_q <= bit_cnt_q - 3'd1;
                        end
                    end
                    ST_ACK_DATA: if (scl_fall) begin
                        if (!sda_low_q) begin
                            sda_low_q <= 1'b1;
                        end else begin
                            sda_low_q <= 1'b0;
                            state_q   <= ST_RX_DATA;
                            bit_cnt_q <= 3'd7;
                        end
                    end
                    ST_TX_DATA: if (scl_fall) begin
                        if (bit_cnt_q == 3'd0) begin
                            sda_low_q  <= 1'b0;
                            ack_seen_q <= 1'b0;
                            state_q    <= ST_RX_ACK;
                        end else begin
                            sda_low_q <= ~tx_q[I2C_DATA_W-2];
                            tx_q      <= {tx_q[I2C_DATA_W-3:0], 1'b0};
                            bit_cnt_q <= bit_cnt_q - 3'd1;
                        end
                    end
                    ST_RX_ACK: begin
                        if (scl_rise) begin
                            if (sda_level == I2C_NACK) begin
                                state_q <= ST_WAIT_STOP;
                            end else begin
                                ack_seen_q <= 1'b1;
                            end
                        end else if (scl_fall && ack_seen_q) begin
                            state_q   <= ST_TX_DATA;
                            tx_q      <= local_if.iw_tx_data[I2C_DATA_W-2:0];
                            sda_low_q <= ~local_if.iw_tx_data[I2C_DATA_W-1];
                            bit_cnt_q <= 3'd7;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign io_i2c_sda           = sda_low_q ? 1'b0 : 1'bz;
    assign local_if.ow_tx_load  = load_now;
    assign local_if.ow_rx_data  = rx_data_q;
    assign local_if.ow_rx_valid = rx_valid_q;
    assign local_if.ow_stop     = stop_q;
    assign local_if.ow_busy     = busy_q;
endmodule

// File: tb/tb_i2c_slave.sv
// Bit-banged I2C master driving i2c_slave; a transaction-level model fills
// expectation queues that a free-running monitor consumes as the DUT pulses.
module tb_i2c_slave;
    import i2c_pkg::*;

    localparam logic [6:0] SLAVE_ADDR = 7'h42;
    localparam int         Q          = 8;

    logic clk       = 1'b0;
    logic rst_n     = 1'b0;
    logic scl       = 1'b1;
    logic sda_m_low = 1'b0;
    wire  sda_bus;

    assign sda_bus = sda_m_low ? 1'b0 : 1'bz;
    pullup pu_sda (sda_bus);

    i2c_slave_if uif ();

    i2c_slave #(
        .SLAVE_ADDR (SLAVE_ADDR),
        .SYNC_STAGES(2),
        .FILTER_LEN (3)
    ) dut (
        .iw_clk    (clk),
        .iw_reset_n(rst_n),
        .iw_i2c_scl(scl),
        .io_i2c_sda(sda_bus),
        .local_if  (uif)
    );

    always #5 clk = ~clk;

    int         n_checks = 0;
    int         n_errors = 0;
    logic [7:0] exp_rx_q[$];
    logic [7:0] exp_load_q[$];
    int         exp_stop_cnt = 0;
    bit         model_busy = 1'b0;
    logic [7:0] data_buf[4];

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic flag(input string name);
        n_checks++;
        n_errors++;
        $display("FAIL %s: DUT pulse with nothing expected", name);
    endtask

    // Monitor: every DUT strobe must match the head of its expectation queue.
    always @(negedge clk) begin
        if (rst_n) begin
            if (uif.ow_rx_valid) begin
                if (exp_rx_q.size() == 0) flag("rx_valid_extra");
                else chk("rx_data", int'(uif.ow_rx_data), int'(exp_rx_q.pop_front()));
            end
            if (uif.ow_tx_load) begin
                if (exp_load_q.size() == 0) flag("tx_load_extra");
                else chk("tx_load_data", int'(uif.iw_tx_data), int'(exp_load_q.pop_front()));
            end
            if (uif.ow_stop) begin
                if (exp_stop_cnt == 0) flag("stop_extra");
                else exp_stop_cnt--;
            end
            if (uif.ow_rx_valid && uif.ow_tx_load) flag("rx_valid_with_tx_load");
        end
    end

    task automatic qwait();
        repeat (Q) @(posedge clk);
    endtask

    task automatic bus_start();
        sda_m_low = 1'b0; qwait();
        scl = 1'b1;       qwait();
        sda_m_low = 1'b1; qwait();
        scl = 1'b0;       qwait();
    endtask

    task automatic bus_stop();
        sda_m_low = 1'b1; qwait();
        scl = 1'b1;       qwait();
        if (model_busy) exp_stop_cnt++;
        model_busy = 1'b0;
        sda_m_low = 1'b0; qwait();
        qwait();
        chk("busy_after_stop", int'(uif.ow_busy), int'(model_busy));
    endtask

    task automatic bus_bit(input logic b, input bit glitch, output logic obs);
        sda_m_low = ~b; qwait();
        scl = 1'b1;
        if (glitch) begin
            repeat (3) @(posedge clk);
            scl = 1'b0;
            @(posedge clk);
            scl = 1'b1;
            repeat (Q - 4) @(posedge clk);
        end else begin
            qwait();
        end
        @(negedge clk);
        obs = sda_bus;
        qwait();
        scl = 1'b0;
        qwait();
    endtask

    task automatic write_byte(input logic [7:0] d, input int glitch_idx, output logic ack);
        logic obs;
        for (int i = 7; i >= 0; i--) begin
            bus_bit(d[i], (i == glitch_idx), obs);
            chk("wr_bit", int'(obs), int'(d[i]));
        end
        bus_bit(1'b1, 1'b0, ack);
    endtask

    task automatic read_byte(output logic [7:0] d);
        logic obs;
        for (int i = 7; i >= 0; i--) begin
            bus_bit(1'b1, 1'b0, obs);
            d[i] = obs;
        end
    endtask

    task automatic xfer(input logic [6:0] addr, input logic rw, input int n);
        logic       ack;
        logic       obs;
        logic [7:0] got;
        bit         match;
        match = (addr == SLAVE_ADDR);
        $display("xfer addr=0x%02h rw=%0d bytes=%0d match=%0d d0=0x%02h", addr, rw, n, match, data_buf[0]);
        if (rw) begin
            uif.iw_tx_data = data_buf[0];
            if (match) exp_load_q.push_back(data_buf[0]);
        end
        bus_start();
        write_byte({addr, rw}, -1, ack);
        chk("addr_ack", int'(ack), int'(match ? I2C_ACK : I2C_NACK));
        model_busy = match;
        chk("busy_after_addr", int'(uif.ow_busy), int'(model_busy));
        for (int i = 0; i < n; i++) begin
            if (!rw) begin
                if (match) exp_rx_q.push_back(data_buf[i]);
                write_byte(data_buf[i], -1, ack);
                chk("data_ack", int'(ack), int'(match ? I2C_ACK : I2C_NACK));
            end else begin
                read_byte(got);
                chk("rd_data", int'(got), int'(match ? data_buf[i] : 8'hFF));
                if (i + 1 < n) begin
                    uif.iw_tx_data = data_buf[i + 1];
                    if (match) exp_load_q.push_back(data_buf[i + 1]);
                end
                bus_bit((i + 1 < n) ? I2C_ACK : I2C_NACK, 1'b0, obs);
                if (i + 1 == n) chk("nack_released", int'(obs), 1);
            end
        end
        bus_stop();
    endtask

    initial begin
        logic ack;
        logic obs;
        uif.iw_tx_data = 8'h00;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_rx_data", int'(uif.ow_rx_data), 0);
        chk("rst_rx_valid", int'(uif.ow_rx_valid), 0);
        chk("rst_busy", int'(uif.ow_busy), 0);
        chk("rst_stop", int'(uif.ow_stop), 0);
        chk("rst_tx_load", int'(uif.ow_tx_load), 0);
        chk("rst_sda", int'(sda_bus), 1);
        rst_n = 1'b1;
        qwait();

        // Directed scenarios
        data_buf[0] = 8'hA5; xfer(7'h42, 1'b0, 1);
        data_buf[0] = 8'hFF; xfer(7'h43, 1'b0, 1);
        data_buf[0] = 8'h3C; xfer(7'h42, 1'b1, 1);
        data_buf[0] = 8'h01; data_buf[1] = 8'h02; data_buf[2] = 8'h03;
        xfer(7'h42, 1'b0, 3);

        // Repeated START after 4 data bits of a write
        $display("xfer addr=0x42 rw=0 partial 4 bits then repeated start");
        bus_start();
        write_byte({7'h42, 1'b0}, -1, ack);
        chk("addr_ack_pre_rs", int'(ack), int'(I2C_ACK));
        model_busy = 1'b1;
        for (int i = 0; i < 4; i++) bus_bit(1'($urandom), 1'b0, obs);
        data_buf[0] = 8'($urandom);
        xfer(7'h42, 1'b1, 1);

        // Asynchronous reset while the target is driving a data ACK
        $display("xfer addr=0x42 rw=0 reset during data ack");
        bus_start();
        write_byte({7'h42, 1'b0}, -1, ack);
        chk("addr_ack_pre_rst", int'(ack), int'(I2C_ACK));
        model_busy = 1'b1;
        exp_rx_q.push_back(8'h96);
        for (int i = 7; i >= 0; i--) begin
            bus_bit(((8'h96 >> i) & 1) != 0, 1'b0, obs);
        end
        sda_m_low = 1'b0;
        qwait();
        @(negedge clk);
        chk("ack_driven_pre_rst", int'(sda_bus), 0);
        rst_n = 1'b0;
        #1;
        chk("rst_sda_released", int'(sda_bus), 1);
        chk("rst_busy_mid", int'(uif.ow_busy), 0);
        chk("rst_rx_data_mid", int'(uif.ow_rx_data), 0);
        chk("rst_rx_valid_mid", int'(uif.ow_rx_valid), 0);
        chk("rst_stop_mid", int'(uif.ow_stop), 0);
        model_busy = 1'b0;
        scl = 1'b1;
        repeat (4) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        qwait();
        data_buf[0] = 8'h5C; data_buf[1] = 8'hC3;
        xfer(7'h42, 1'b0, 2);

`ifdef I2C_SLAVE_GLITCH_FILTER_EN
        // One-cycle SCL low glitch in the middle of a data bit
        $display("xfer addr=0x42 rw=0 data=0x5A with scl glitch");
        bus_start();
        write_byte({7'h42, 1'b0}, -1, ack);
        chk("addr_ack_glitch", int'(ack), int'(I2C_ACK));
        model_busy = 1'b1;
        exp_rx_q.push_back(8'h5A);
        write_byte(8'h5A, 4, ack);
        chk("data_ack_glitch", int'(ack), int'(I2C_ACK));
        bus_stop();
`endif

        // Randomized transactions
        for (int t = 0; t < 8; t++) begin
            logic [6:0] a;
            a = ($urandom_range(0, 2) == 0) ? 7'($urandom) : SLAVE_ADDR;
            for (int k = 0; k < 4; k++) data_buf[k] = 8'($urandom);
            xfer(a, 1'($urandom), int'($urandom_range(1, 3)));
        end

        repeat (50) @(posedge clk);
        chk("rx_pending", exp_rx_q.size(), 0);
        chk("load_pending", exp_load_q.size(), 0);
        chk("stop_pending", exp_stop_cnt, 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end
endmodule
